alu_cmd_driver: RTL and testbench

- Initiator for the team's combinational Alu; the Alu remains the responder.
- Accepts operation commands over a valid/ready interface and drives the Alu operand, op and unsig inputs from registers.
- Waits a fixed settle time, captures aluout, compout and overflow, and returns them over a valid/ready response interface.
- Keeps a sticky overflow status and a completed-operation counter for the CPU datapath and debug logic.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_driver.sv | 200 ++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Alu command driver: op encodings, op
// classification helpers and the driver FSM state encoding.
package alu_pkg;

    // Alu op encodings
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    // Width of the settle counter; holds SETTLE_CYCLES-1 for SETTLE_CYCLES in 1..15
    localparam int SETTLE_W = 4;

    // Driver FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // True for every op the Alu implements
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
               (op == OP_NOR) || (op == OP_XOR) || (op == OP_SUB);
    endfunction

    // True for the ops whose overflow flag is meaningful (signed ADD/SUB)
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Alu command driver: accepts commands over valid/ready, drives the
// combinational Alu from registers, waits a fixed settle time, captures the
// Alu outputs and returns them over a valid/ready response channel. Also
// keeps a sticky overflow flag and a completed-response counter.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_unsig,
    // Alu operand side
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_unsig,
    // Alu result side
    input  logic [31:0]      alu_out,
    input  logic             alu_compout,
    input  logic             alu_overflow,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_compout,
    output logic             rsp_overflow,
    output logic             rsp_illegal,
    // status
    output logic             ovf_sticky,
    input  logic             ovf_clear,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    logic [31:0]         alu_a_q, alu_b_q;
    logic [2:0]          alu_op_q;
    logic                alu_unsig_q;

    logic [31:0]         rsp_result_q;
    logic                rsp_compout_q;
    logic                rsp_overflow_q;
    logic                rsp_illegal_q;

    logic                ovf_sticky_q, ovf_sticky_d;
    logic [CNT_W-1:0]    op_count_q, op_count_d;

    // Decoded events for the current cycle
    logic                accept_legal;
    logic                accept_illegal;
    logic                capture;
    logic                rsp_hs;
    logic                cap_overflow;

    // Overflow is only meaningful for signed ADD/SUB; mask it for everything else
    assign cap_overflow = alu_overflow & is_arith_op(alu_op_q) & ~alu_unsig_q;

    // Next-state, handshake outputs and event decode
    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        capture        = 1'b0;
        rsp_hs         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = ~reset;
                if (cmd_valid) begin
                    if (is_legal_op(cmd_op)) begin
                        accept_legal = 1'b1;
                        state_d      = ST_EXEC;
                    end else begin
                        // illegal ops never reach the Alu; answer immediately
                        accept_illegal = 1'b1;
                        state_d        = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Settle counter: loaded on accept, counts down while in EXEC
    always_comb begin
        cnt_d = cnt_q;
        if (accept_legal) begin
            cnt_d = SETTLE_LOAD;
        end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    // Sticky overflow: a capture that sets the flag wins over a same-edge clear
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (capture && cap_overflow) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky_d = 1'b0;
        end
    end

    // Completed-response counter, wraps naturally
    always_comb begin
        op_count_d = op_count_q;
        if (rsp_hs) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // FSM state, settle counter and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            op_count_q   <= op_count_d;
        end
    end

    // Alu input registers: only a legal accept changes them, so the Alu sees stable operands
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_unsig_q <= 1'b0;
        end else if (accept_legal) begin
            alu_a_q     <= cmd_a;
            alu_b_q     <= cmd_b;
            alu_op_q    <= cmd_op;
            alu_unsig_q <= cmd_unsig;
        end
    end

    // Response registers: written on capture or illegal accept, held through RESP
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_result_q   <= '0;
            rsp_compout_q  <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_illegal_q  <= 1'b0;
        end else if (capture) begin
            rsp_result_q   <= alu_out;
            rsp_compout_q  <= alu_compout;
            rsp_overflow_q <= cap_overflow;
            rsp_illegal_q  <= 1'b0;
        end else if (accept_illegal) begin
            rsp_result_q   <= '0;
            rsp_compout_q  <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_illegal_q  <= 1'b1;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_unsig    = alu_unsig_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_compout  = rsp_compout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_illegal  = rsp_illegal_q;
    assign ovf_sticky   = ovf_sticky_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural Alu as responder.
module tb_alu_cmd_driver;

    localparam int SETTLE = 3;
    localparam int CNT_W  = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a, cmd_b;
    logic [2:0]       cmd_op;
    logic             cmd_unsig;
    logic [31:0]      alu_a, alu_b;
    logic [2:0]       alu_op;
    logic             alu_unsig;
    logic [31:0]      alu_out;
    logic             alu_compout;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_compout;
    logic             rsp_overflow;
    logic             rsp_illegal;
    logic             ovf_sticky;
    logic             ovf_clear;
    logic [CNT_W-1:0] op_count;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    always #5 clock = ~clock;

    alu_cmd_driver #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_unsig(cmd_unsig),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_unsig(alu_unsig),
        .alu_out(alu_out), .alu_compout(alu_compout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_compout(rsp_compout),
        .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
        .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear), .op_count(op_count)
    );

    // Behavioural Alu responder; overflow reports signed overflow regardless of unsig
    logic [31:0] sum, diff;
    always_comb begin
        sum          = alu_a + alu_b;
        diff         = alu_a - alu_b;
        alu_out      = 32'h0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: alu_out = alu_a & alu_b;
            3'b001: alu_out = alu_a | alu_b;
            3'b010: begin
                alu_out      = sum;
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'b100: alu_out = ~(alu_a | alu_b);
            3'b101: alu_out = alu_a ^ alu_b;
            3'b110: begin
                alu_out      = diff;
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            default: alu_out = 32'h0;
        endcase
        alu_compout = alu_unsig ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
    end

    // Present one command for one cycle; returns at the negedge after the accept edge
    task automatic do_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic u);
        @(negedge clock);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_unsig = u; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Count clock edges until rsp_valid, bounded
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    // One-cycle response handshake
    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_unsig = 1'b0; rsp_ready = 1'b0; ovf_clear = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (op_count !== '0) begin bad++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
        total++; if ({alu_a, alu_b, alu_op, alu_unsig} !== '0) begin bad++; $display("FAIL reset_alu got=%h/%h/%b want=0", alu_a, alu_b, alu_op); end
        total++; if ({rsp_result, rsp_compout, rsp_overflow, rsp_illegal, ovf_sticky} !== '0) begin bad++; $display("FAIL reset_rsp got=%h ovf=%b ill=%b sticky=%b want=0", rsp_result, rsp_overflow, rsp_illegal, ovf_sticky); end
        reset = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        exp_count = 0;
    endtask

    task automatic test_logic_arith();
        int cyc;
        do_cmd(32'h43667107, 32'h0CC64678, 3'b000, 1'b0);
        wait_rsp(cyc);
        total++; if (cyc != SETTLE) begin bad++; $display("FAIL and_latency got=%0d want=%0d", cyc, SETTLE); end
        total++; if (rsp_result !== 32'h00464000) begin bad++; $display("FAIL and_result got=%h want=00464000", rsp_result); end
        total++; if (rsp_illegal !== 1'b0 || rsp_compout !== 1'b0) begin bad++; $display("FAIL and_flags got ill=%b cmp=%b want 0/0", rsp_illegal, rsp_compout); end
        handshake();
        do_cmd(32'h43667107, 32'h0CC64678, 3'b010, 1'b0);
        wait_rsp(cyc);
        total++; if (rsp_result !== 32'h502CB77F) begin bad++; $display("FAIL add_result got=%h want=502CB77F", rsp_result); end
        total++; if (rsp_overflow !== 1'b0) begin bad++; $display("FAIL add_overflow got=%b want=0", rsp_overflow); end
        handshake();
        do_cmd(32'h43667107, 32'h0CC64678, 3'b110, 1'b0);
        wait_rsp(cyc);
        total++; if (rsp_result !== 32'h36A02A8F) begin bad++; $display("FAIL sub_result got=%h want=36A02A8F", rsp_result); end
        handshake();
        total++; if (op_count !== 16'd3) begin bad++; $display("FAIL count_after_three got=%0d want=3", op_count); end
    endtask

    task automatic test_signed_overflow();
        int cyc;
        do_cmd(32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b0);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL exec_cmd_ready got=%b want=0", cmd_ready); end
        wait_rsp(cyc);
        total++; if (cyc != SETTLE) begin bad++; $display("FAIL ovf_latency got=%0d want=%0d", cyc, SETTLE); end
        total++; if (rsp_result !== 32'hFFFFFFFE) begin bad++; $display("FAIL ovf_result got=%h want=FFFFFFFE", rsp_result); end
        total++; if (rsp_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", rsp_overflow); end
        total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf_sticky); end
        handshake();
    endtask

    task automatic test_illegal();
        int cyc;
        do_cmd(32'hDEADBEEF, 32'h12345678, 3'b011, 1'b0);
        wait_rsp(cyc);
        total++; if (cyc != 0 || rsp_valid !== 1'b1) begin bad++; $display("FAIL ill_latency got=%0d valid=%b want=0 valid=1", cyc, rsp_valid); end
        total++; if (rsp_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b want=1", rsp_illegal); end
        total++; if (rsp_result !== 32'h0 || rsp_overflow !== 1'b0) begin bad++; $display("FAIL ill_fields got=%h ovf=%b want=0 ovf=0", rsp_result, rsp_overflow); end
        total++; if (alu_op !== 3'b010 || alu_a !== 32'h7FFFFFFF) begin bad++; $display("FAIL ill_alu_hold got op=%b a=%h want op=010 a=7FFFFFFF", alu_op, alu_a); end
        handshake();
        total++; if (op_count !== CNT_W'(exp_count)) begin bad++; $display("FAIL ill_count got=%0d want=%0d", op_count, exp_count); end
        do_cmd(32'h1, 32'h2, 3'b111, 1'b1);
        wait_rsp(cyc);
        total++; if (cyc != 0 || rsp_illegal !== 1'b1) begin bad++; $display("FAIL ill111 got cyc=%0d ill=%b want 0/1", cyc, rsp_illegal); end
        handshake();
    endtask

    task automatic test_more_ops();
        int cyc;
        do_cmd(32'h00000001, 32'h00000002, 3'b001, 1'b1);
        wait_rsp(cyc);
        total++; if (rsp_result !== 32'h3 || rsp_compout !== 1'b1 || rsp_illegal !== 1'b0) begin bad++; $display("FAIL or_rsp got=%h cmp=%b ill=%b want=3/1/0", rsp_result, rsp_compout, rsp_illegal); end
        handshake();
        do_cmd(32'hF0F0F0F0, 32'h0FF00FF0, 3'b101, 1'b0);
        wait_rsp(cyc);
        total++; if (rsp_result !== 32'hFF00FF00 || rsp_compout !== 1'b1) begin bad++; $display("FAIL xor_rsp got=%h cmp=%b want=FF00FF00/1", rsp_result, rsp_compout); end
        handshake();
        do_cmd(32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 1'b0);
        wait_rsp(cyc);
        total++; if (rsp_result !== 32'h000F000F) begin bad++; $display("FAIL nor_rsp got=%h want=000F000F", rsp_result); end
        handshake();
        do_cmd(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b1);
        wait_rsp(cyc);
        total++; if (rsp_result !== 32'h80000000 || rsp_overflow !== 1'b0) begin bad++; $display("FAIL uadd_rsp got=%h ovf=%b want=80000000/0", rsp_result, rsp_overflow); end
        handshake();
        total++; if (op_count !== CNT_W'(exp_count)) begin bad++; $display("FAIL more_count got=%0d want=%0d", op_count, exp_count); end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_cmd(32'hFFFF0000, 32'h12345678, 3'b000, 1'b0);
        wait_rsp(cyc);
        cmd_a = 32'h00FF00FF; cmd_b = 32'h0F000000; cmd_op = 3'b001; cmd_unsig = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h12340000 || cmd_ready !== 1'b0 || alu_a !== 32'hFFFF0000) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b r=%h rdy=%b a=%h want 1/12340000/0/FFFF0000", i, rsp_valid, rsp_result, cmd_ready, alu_a);
            end
        end
        handshake();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 32'hFFFF0000) begin bad++; $display("FAIL bp_after_hs got v=%b rdy=%b a=%h want 0/1/FFFF0000", rsp_valid, cmd_ready, alu_a); end
        @(negedge clock);
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0 || alu_a !== 32'h00FF00FF) begin bad++; $display("FAIL bp_next_accept got rdy=%b a=%h want 0/00FF00FF", cmd_ready, alu_a); end
        wait_rsp(cyc);
        total++; if (cyc != SETTLE || rsp_result !== 32'h0FFF00FF) begin bad++; $display("FAIL bp_next_rsp got cyc=%0d r=%h want %0d/0FFF00FF", cyc, rsp_result, SETTLE); end
        handshake();
    endtask

    task automatic test_sticky();
        int cyc;
        @(negedge clock);
        ovf_clear = 1'b1;
        @(negedge clock);
        total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL sticky_pre_clear got=%b want=0", ovf_sticky); end
        do_cmd(32'h80000000, 32'h00000001, 3'b110, 1'b0);
        wait_rsp(cyc);
        total++; if (rsp_overflow !== 1'b1 || rsp_result !== 32'h7FFFFFFF) begin bad++; $display("FAIL sticky_sub_ovf got ovf=%b r=%h want 1/7FFFFFFF", rsp_overflow, rsp_result); end
        total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got=%b want=1", ovf_sticky); end
        ovf_clear = 1'b0;
        handshake();
        total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL sticky_hold got=%b want=1", ovf_sticky); end
        ovf_clear = 1'b1;
        @(negedge clock);
        ovf_clear = 1'b0;
        total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b want=0", ovf_sticky); end
    endtask

    task automatic test_reset_mid();
        logic stale;
        do_cmd(32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b0);
        total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_in_exec got rdy=%b v=%b want 0/0", cmd_ready, rsp_valid); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || op_count !== '0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ctrl got v=%b cnt=%0d rdy=%b want 0/0/1", rsp_valid, op_count, cmd_ready); end
        total++; if ({alu_a, alu_b, alu_op, alu_unsig} !== '0 || ovf_sticky !== 1'b0) begin bad++; $display("FAIL mid_alu got a=%h b=%h op=%b sticky=%b want 0", alu_a, alu_b, alu_op, ovf_sticky); end
        exp_count = 0;
        stale = 1'b0;
        repeat (2 * SETTLE + 4) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0) stale = 1'b1;
        end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL mid_stale_rsp got=%b want=0", stale); end
    endtask

    initial begin
        test_reset();
        test_logic_arith();
        test_signed_overflow();
        test_illegal();
        test_more_ops();
        test_backpressure();
        test_sticky();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
